// File: rtl/pdp1_sbs_pkg.sv
// Shared definitions for the PDP-1 sequence-break controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package pdp1_sbs_pkg;

  // Number of sequence-break channels; index 0 is channel 1, the highest priority
  localparam int SBS_NCHAN = 4;

  // Model selectors, right-aligned in a 40-bit field so both compare cleanly
  localparam logic [39:0] SBS_MODEL_SBS   = {16'h0000, "SBS"};
  localparam logic [39:0] SBS_MODEL_SBS16 = "SBS16";

  // Break handshake state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SAVE = 2'd2
  } sbs_state_t;

  // One-hot channel vector, bit 0 = channel 1
  function automatic logic [0:3] chan_onehot(input logic [1:0] idx);
    logic [0:3] v;
    v      = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pdp1_sbs_prio.sv
// Priority encoder: picks the highest-priority channel allowed to break now.
// Latency: combinational.
// Backpressure: none; output is a pure function of the current flags.
module pdp1_sbs_prio
  import pdp1_sbs_pkg::*;
(
  input  logic       i_mode,
  input  logic [0:3] i_pending,
  input  logic [0:3] i_enable,
  input  logic [0:3] i_inserv,
  output logic       o_vld,
  output logic [1:0] o_idx
);

  logic [0:3] w_elig;
  logic       w_blk;

  // A channel is blocked by its own in-service flag or any higher-priority one
  always_comb begin
    w_blk  = 1'b0;
    w_elig = 4'b0000;
    for (int i = 0; i < SBS_NCHAN; i++) begin
      w_blk     = w_blk | i_inserv[i];
      w_elig[i] = i_mode & i_pending[i] & i_enable[i] & ~w_blk;
    end
  end

  // Scan from lowest priority upward so the lowest index is the last to win
  always_comb begin
    o_vld = 1'b0;
    o_idx = 2'd0;
    for (int i = SBS_NCHAN - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        o_vld = 1'b1;
        o_idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/pdp1_sbs_controller.sv
// PDP-1 sequence-break controller: latches requests, arbitrates, runs CPU break handshake.
// Latency: request edge to sb_break_req is 2 clocks; cpu_ack to sb_ireqN is 1 clock.
// Backpressure: break_req holds until cpu_ack; ireq holds through SAVE until cpu_done.
module pdp1_sbs_controller
  import pdp1_sbs_pkg::*;
#(
  parameter logic [39:0] sbs_model = SBS_MODEL_SBS16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [0:3] i_sb_req,
  input  logic       i_cmd_esm,
  input  logic       i_cmd_lsm,
  input  logic       i_cmd_cbs,
  input  logic       i_cmd_asc,
  input  logic       i_cmd_dsc,
  input  logic       i_cmd_isb,
  input  logic [0:1] i_cmd_chan,
  input  logic       i_cpu_ack,
  input  logic       i_cpu_done,
  input  logic       i_cpu_debreak,
  output logic       o_sb_break_req,
  output logic       o_sb_ireq1,
  output logic       o_sb_ireq2,
  output logic       o_sb_ireq3,
  output logic       o_sb_ireq4,
  output logic       o_sb_mode,
  output logic [0:3] o_sb_pending,
  output logic [0:3] o_sb_inserv,
  output logic       o_sb_busy
);

  // Single-channel model folds every request onto channel 1 and ignores enables
  localparam bit SINGLE = (sbs_model == SBS_MODEL_SBS);

  sbs_state_t r_state;
  logic [1:0] r_chan_q;
  logic [0:3] r_req_q;
  logic [0:3] r_pending;
  logic [0:3] r_inserv;
  logic [0:3] r_enable;
  logic [0:3] r_ireq;
  logic       r_mode;
  logic       r_break_req;

  logic [0:3] w_edge;
  logic [0:3] w_isb_vec;
  logic [0:3] w_raw_set;
  logic [0:3] w_set;
  logic [0:3] w_asc_vec;
  logic [0:3] w_dsc_vec;
  logic [0:3] w_enable_eff;
  logic [0:3] w_lowest_ins;
  logic [0:3] w_chan_vec;
  logic [0:3] w_pend_clr;
  logic [0:3] w_ins_base;
  logic       w_abort;
  logic       w_take;
  logic       w_vld;
  logic [1:0] w_idx;

  // New requests: rising device levels plus software-initiated breaks
  assign w_edge    = i_sb_req & ~r_req_q;
  assign w_isb_vec = i_cmd_isb ? chan_onehot(i_cmd_chan) : 4'b0000;
  assign w_raw_set = w_edge | w_isb_vec;
  assign w_set     = SINGLE ? {(|w_raw_set), 3'b000} : w_raw_set;

  assign w_asc_vec    = i_cmd_asc ? chan_onehot(i_cmd_chan) : 4'b0000;
  assign w_dsc_vec    = i_cmd_dsc ? chan_onehot(i_cmd_chan) : 4'b0000;
  assign w_enable_eff = SINGLE ? 4'b1111 : r_enable;

  // Leaving break mode or clearing the flags both cancel an unacknowledged request
  assign w_abort    = i_cmd_cbs | i_cmd_lsm;
  assign w_take     = (r_state == ST_REQ) & ~w_abort & i_cpu_ack;
  assign w_chan_vec = chan_onehot(r_chan_q);

  // Debreak retires the highest-priority (lowest-index) channel in service
  always_comb begin
    w_lowest_ins = 4'b0000;
    for (int i = SBS_NCHAN - 1; i >= 0; i--) begin
      if (r_inserv[i]) w_lowest_ins = chan_onehot(2'(i));
    end
  end

  // Clear first, then set: a request arriving with cbs or ack survives
  assign w_pend_clr = (i_cmd_cbs ? 4'b1111 : 4'b0000) | (w_take ? w_chan_vec : 4'b0000);
  assign w_ins_base = i_cmd_cbs ? 4'b0000
                                : (r_inserv & ~(i_cpu_debreak ? w_lowest_ins : 4'b0000));

  pdp1_sbs_prio u_prio (
    .i_mode    (r_mode),
    .i_pending (r_pending),
    .i_enable  (w_enable_eff),
    .i_inserv  (r_inserv),
    .o_vld     (w_vld),
    .o_idx     (w_idx)
  );

  // Edge-detect history of the device request levels
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_req_q <= 4'b0000;
    else          r_req_q <= i_sb_req;
  end

  // Sequence-break mode; leave wins over enter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_mode <= 1'b0;
    else if (i_cmd_lsm) r_mode <= 1'b0;
    else if (i_cmd_esm) r_mode <= 1'b1;
  end

  // Channel enable mask; deactivate wins over activate on the same channel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_enable <= 4'b1111;
    else if (!SINGLE) r_enable <= (r_enable | w_asc_vec) & ~w_dsc_vec;
  end

  // Pending flags: cleared by cbs or acceptance, set by new requests
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pending <= 4'b0000;
    else          r_pending <= (r_pending & ~w_pend_clr) | w_set;
  end

  // In-service flags: debreak/cbs clear before the accepted channel is marked
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_inserv <= 4'b0000;
    else          r_inserv <= w_ins_base | (w_take ? w_chan_vec : 4'b0000);
  end

  // Break handshake with the CPU sequencer, outputs registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_chan_q    <= 2'd0;
      r_break_req <= 1'b0;
      r_ireq      <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_vld && !w_abort) begin
            r_state     <= ST_REQ;
            r_chan_q    <= w_idx;
            r_break_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (w_abort) begin
            r_state     <= ST_IDLE;
            r_break_req <= 1'b0;
          end else if (i_cpu_ack) begin
            r_state     <= ST_SAVE;
            r_break_req <= 1'b0;
            r_ireq      <= w_chan_vec;
          end
        end
        ST_SAVE: begin
          if (i_cpu_done) begin
            r_state <= ST_IDLE;
            r_ireq  <= 4'b0000;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_break_req <= 1'b0;
          r_ireq      <= 4'b0000;
        end
      endcase
    end
  end

  assign o_sb_break_req = r_break_req;
  assign o_sb_ireq1     = r_ireq[0];
  assign o_sb_ireq2     = r_ireq[1];
  assign o_sb_ireq3     = r_ireq[2];
  assign o_sb_ireq4     = r_ireq[3];
  assign o_sb_mode      = r_mode;
  assign o_sb_pending   = r_pending;
  assign o_sb_inserv    = r_inserv;
  assign o_sb_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pdp1_sbs_controller.sv
// Bench for the sequence-break controller: SBS16 and SBS instances share stimulus.
// Each instance is tracked by its own behavioural model and compared every cycle.
// Directed scenarios first, then randomized traffic.
module tb_pdp1_sbs_controller;
  import pdp1_sbs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [0:3] sb_req;
  logic       cmd_esm, cmd_lsm, cmd_cbs, cmd_asc, cmd_dsc, cmd_isb;
  logic [1:0] cmd_chan;
  logic       cpu_ack, cpu_done, cpu_debreak;

  logic       a_br, a_i1, a_i2, a_i3, a_i4, a_mode, a_busy;
  logic [0:3] a_pend, a_ins;
  logic       b_br, b_i1, b_i2, b_i3, b_i4, b_mode, b_busy;
  logic [0:3] b_pend, b_ins;

  int total = 0;
  int bad   = 0;

  pdp1_sbs_controller #(.sbs_model(SBS_MODEL_SBS16)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sb_req(sb_req),
    .i_cmd_esm(cmd_esm), .i_cmd_lsm(cmd_lsm), .i_cmd_cbs(cmd_cbs),
    .i_cmd_asc(cmd_asc), .i_cmd_dsc(cmd_dsc), .i_cmd_isb(cmd_isb), .i_cmd_chan(cmd_chan),
    .i_cpu_ack(cpu_ack), .i_cpu_done(cpu_done), .i_cpu_debreak(cpu_debreak),
    .o_sb_break_req(a_br), .o_sb_ireq1(a_i1), .o_sb_ireq2(a_i2), .o_sb_ireq3(a_i3),
    .o_sb_ireq4(a_i4), .o_sb_mode(a_mode), .o_sb_pending(a_pend), .o_sb_inserv(a_ins),
    .o_sb_busy(a_busy)
  );

  pdp1_sbs_controller #(.sbs_model(SBS_MODEL_SBS)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sb_req(sb_req),
    .i_cmd_esm(cmd_esm), .i_cmd_lsm(cmd_lsm), .i_cmd_cbs(cmd_cbs),
    .i_cmd_asc(cmd_asc), .i_cmd_dsc(cmd_dsc), .i_cmd_isb(cmd_isb), .i_cmd_chan(cmd_chan),
    .i_cpu_ack(cpu_ack), .i_cpu_done(cpu_done), .i_cpu_debreak(cpu_debreak),
    .o_sb_break_req(b_br), .o_sb_ireq1(b_i1), .o_sb_ireq2(b_i2), .o_sb_ireq3(b_i3),
    .o_sb_ireq4(b_i4), .o_sb_mode(b_mode), .o_sb_pending(b_pend), .o_sb_inserv(b_ins),
    .o_sb_busy(b_busy)
  );

  // Reference model, index 0 = SBS16 instance, 1 = SBS instance
  logic [0:3] m_pend[2], m_ins[2], m_en[2], m_hist[2], m_ireq[2];
  logic       m_mode[2], m_wait[2], m_save[2];
  int         m_chan[2];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int m);
    m_pend[m] = 4'b0000; m_ins[m] = 4'b0000; m_en[m] = 4'b1111;
    m_hist[m] = 4'b0000; m_ireq[m] = 4'b0000;
    m_mode[m] = 1'b0; m_wait[m] = 1'b0; m_save[m] = 1'b0; m_chan[m] = 0;
  endtask

  // One clock of the rules: arbitration sees the flags as they stood before the edge
  task automatic model_step(input int m);
    logic [0:3] setv, np, ns;
    int win;
    bit single;
    single = (m == 1);
    setv = sb_req & ~m_hist[m];
    if (cmd_isb) setv[cmd_chan] = 1'b1;
    if (single) setv = (setv != 4'b0000) ? 4'b1000 : 4'b0000;
    win = -1;
    if (m_mode[m]) begin
      for (int c = 0; c < 4; c++) begin
        if (m_ins[m][c]) break;
        if (m_pend[m][c] && (single || m_en[m][c])) begin
          win = c;
          break;
        end
      end
    end
    np = cmd_cbs ? 4'b0000 : m_pend[m];
    ns = m_ins[m];
    if (cpu_debreak) begin
      for (int c = 0; c < 4; c++) begin
        if (ns[c]) begin
          ns[c] = 1'b0;
          break;
        end
      end
    end
    if (cmd_cbs) ns = 4'b0000;
    if (m_wait[m]) begin
      if (cmd_cbs || cmd_lsm) m_wait[m] = 1'b0;
      else if (cpu_ack) begin
        m_wait[m] = 1'b0;
        m_save[m] = 1'b1;
        np[m_chan[m]] = 1'b0;
        ns[m_chan[m]] = 1'b1;
        m_ireq[m] = 4'b0000;
        m_ireq[m][m_chan[m]] = 1'b1;
      end
    end else if (m_save[m]) begin
      if (cpu_done) begin
        m_save[m] = 1'b0;
        m_ireq[m] = 4'b0000;
      end
    end else if (win >= 0 && !cmd_cbs && !cmd_lsm) begin
      m_wait[m] = 1'b1;
      m_chan[m] = win;
    end
    m_pend[m] = np | setv;
    m_ins[m]  = ns;
    if (cmd_lsm) m_mode[m] = 1'b0;
    else if (cmd_esm) m_mode[m] = 1'b1;
    if (!single) begin
      if (cmd_asc) m_en[m][cmd_chan] = 1'b1;
      if (cmd_dsc) m_en[m][cmd_chan] = 1'b0;
    end
    m_hist[m] = sb_req;
  endtask

  task automatic compare(input int m);
    logic [0:3] ir, pd, is;
    logic br, md, bs;
    string p;
    if (m == 0) begin
      ir = {a_i1, a_i2, a_i3, a_i4}; pd = a_pend; is = a_ins; br = a_br; md = a_mode; bs = a_busy;
      p = "sbs16";
    end else begin
      ir = {b_i1, b_i2, b_i3, b_i4}; pd = b_pend; is = b_ins; br = b_br; md = b_mode; bs = b_busy;
      p = "sbs";
    end
    chk({p, ".break_req"}, {7'd0, br}, {7'd0, m_wait[m]});
    chk({p, ".ireq"},      {4'd0, ir}, {4'd0, m_ireq[m]});
    chk({p, ".mode"},      {7'd0, md}, {7'd0, m_mode[m]});
    chk({p, ".pending"},   {4'd0, pd}, {4'd0, m_pend[m]});
    chk({p, ".inserv"},    {4'd0, is}, {4'd0, m_ins[m]});
    chk({p, ".busy"},      {7'd0, bs}, {7'd0, (m_wait[m] | m_save[m])});
    chk({p, ".br_and_ireq"}, {7'd0, (br & (|ir))}, 8'd0);
    if (m == 1) chk("sbs.ireq_not_ch1", {5'd0, ir[1:3]}, 8'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    compare(0);
    compare(1);
    {cmd_esm, cmd_lsm, cmd_cbs, cmd_asc, cmd_dsc, cmd_isb} = 6'b0;
    {cpu_ack, cpu_done, cpu_debreak} = 3'b0;
  endtask

  task automatic run_break();
    cpu_ack = 1'b1;     cycle();
    cpu_done = 1'b1;    cycle();
    cpu_debreak = 1'b1; cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    sb_req = 4'b0000;
    {cmd_esm, cmd_lsm, cmd_cbs, cmd_asc, cmd_dsc, cmd_isb} = 6'b0;
    cmd_chan = 2'd0;
    {cpu_ack, cpu_done, cpu_debreak} = 3'b0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    @(negedge clk);
    compare(0);
    compare(1);
    rst_n = 1'b1;

    // Channel 2 break, 2-clock latency, ack and done
    cmd_esm = 1'b1; cycle();
    chk("A.mode", {7'd0, a_mode}, 8'd1);
    sb_req = 4'b0100; cycle();
    chk("A.pend_ch2", {4'd0, a_pend}, 8'b0100);
    chk("A.br_1clk", {7'd0, a_br}, 8'd0);
    cycle();
    chk("A.br_2clk", {7'd0, a_br}, 8'd1);
    cpu_ack = 1'b1; cycle();
    chk("A.ireq2", {4'd0, a_i1, a_i2, a_i3, a_i4}, 8'b0100);
    chk("A.inserv", {4'd0, a_ins}, 8'b0100);
    chk("A.pend_clr", {4'd0, a_pend}, 8'd0);
    chk("A.sbs_ireq1", {4'd0, b_i1, b_i2, b_i3, b_i4}, 8'b1000);
    cpu_done = 1'b1; cycle();
    chk("A.ireq_done", {4'd0, a_i1, a_i2, a_i3, a_i4}, 8'd0);
    sb_req = 4'b0000; cpu_debreak = 1'b1; cycle();

    // Channel 3 in service, channel 1 nests, channel 4 waits for both debreaks
    sb_req = 4'b0010; cycle(); cycle();
    cpu_ack = 1'b1; cycle();
    chk("B.inserv3", {4'd0, a_ins}, 8'b0010);
    cpu_done = 1'b1; cycle();
    sb_req = 4'b1011; cycle(); cycle();
    cpu_ack = 1'b1; cycle();
    chk("B.nest_ireq1", {4'd0, a_i1, a_i2, a_i3, a_i4}, 8'b1000);
    chk("B.nest_inserv", {4'd0, a_ins}, 8'b1010);
    chk("B.ch4_pend", {4'd0, a_pend}, 8'b0001);
    cpu_done = 1'b1; cycle();
    cpu_debreak = 1'b1; cycle();
    chk("B.debreak1", {4'd0, a_ins}, 8'b0010);
    chk("B.ch4_blocked", {7'd0, a_br}, 8'd0);
    cpu_debreak = 1'b1; cycle();
    cycle();
    chk("B.ch4_br", {7'd0, a_br}, 8'd1);
    sb_req = 4'b0000;
    run_break();

    // Disabled channel stays pending until re-activated
    cmd_dsc = 1'b1; cmd_chan = 2'd0; cycle();
    sb_req = 4'b1000; cycle(); cycle(); cycle();
    chk("C.pend", {4'd0, a_pend}, 8'b1000);
    chk("C.no_br", {7'd0, a_br}, 8'd0);
    cmd_asc = 1'b1; cycle();
    cycle();
    chk("C.br_after_asc", {7'd0, a_br}, 8'd1);
    sb_req = 4'b0000;
    run_break();

    // Software break with mode off, then enter mode
    cmd_lsm = 1'b1; cycle();
    cycle(); cycle();
    cmd_isb = 1'b1; cmd_chan = 2'd2; cycle();
    chk("D.pend_isb", {4'd0, a_pend}, 8'b0010);
    cycle(); cycle();
    chk("D.no_br", {7'd0, a_br}, 8'd0);
    cmd_esm = 1'b1; cycle(); cycle();
    cpu_ack = 1'b1; cycle();
    chk("D.ireq3", {4'd0, a_i1, a_i2, a_i3, a_i4}, 8'b0010);
    cpu_done = 1'b1; cycle();
    cpu_debreak = 1'b1; cycle();

    // lsm aborts REQ keeping pending; cbs with a coincident edge
    sb_req = 4'b0100; cycle(); cycle();
    cmd_lsm = 1'b1; cycle();
    chk("E.lsm_br", {7'd0, a_br}, 8'd0);
    chk("E.lsm_idle", {7'd0, a_busy}, 8'd0);
    chk("E.lsm_pend", {4'd0, a_pend}, 8'b0100);
    sb_req = 4'b0000; cmd_esm = 1'b1; cycle(); cycle();
    cmd_cbs = 1'b1; sb_req = 4'b0100; cycle();
    chk("E.cbs_pend", {4'd0, a_pend}, 8'b0100);
    chk("E.cbs_inserv", {4'd0, a_ins}, 8'd0);
    chk("E.cbs_br", {7'd0, a_br}, 8'd0);
    cycle();
    run_break();
    sb_req = 4'b0000; cycle();

    // Asynchronous reset in the middle of SAVE
    sb_req = 4'b0001; cycle(); cycle();
    cpu_ack = 1'b1; cycle();
    chk("F.ireq4", {4'd0, a_i1, a_i2, a_i3, a_i4}, 8'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("F.rst_a", {a_br, a_i1, a_i2, a_i3, a_i4, a_mode, a_busy, 1'b0}, 8'd0);
    chk("F.rst_a_flags", {a_pend, a_ins}, 8'd0);
    chk("F.rst_b", {b_br, b_i1, b_i2, b_i3, b_i4, b_mode, b_busy, 1'b0}, 8'd0);
    chk("F.rst_b_flags", {b_pend, b_ins}, 8'd0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    sb_req = 4'b0000;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, 3);
        sb_req[k] = ~sb_req[k];
      end
      cmd_esm     = ($urandom_range(0, 9) == 0);
      cmd_lsm     = ($urandom_range(0, 39) == 0);
      cmd_cbs     = ($urandom_range(0, 49) == 0);
      cmd_asc     = ($urandom_range(0, 14) == 0);
      cmd_dsc     = ($urandom_range(0, 19) == 0);
      cmd_isb     = ($urandom_range(0, 14) == 0);
      cmd_chan    = 2'($urandom_range(0, 3));
      cpu_ack     = ($urandom_range(0, 2) == 0);
      cpu_done    = ($urandom_range(0, 2) == 0);
      cpu_debreak = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
